maquina_de_cafe: RTL and testbench

Coin-operated beverage controller for the vending datapath. It is a single Moore finite-state machine that accepts a coin and checks water. It waits for a coffee or tea selection, checks coffee stock and coin value, and then either dispenses, with change where applicable, or returns the coin. All outputs are decoded from the registered state. The block drives the dispenser and coin-return actuators directly.

---
 rtl/maquina_de_cafe.sv | 88 ++++++++
 tb/tb_maquina_de_cafe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/maquina_de_cafe.sv
// Coin-operated coffee/tea controller: one Moore FSM, outputs decoded from state
// and latched coin type, registered so there is no input-to-output path.
module maquina_de_cafe (
    input  logic       clk,
    input  logic       rst,
    input  logic       hm,
    input  logic       ha,
    input  logic       bp,
    input  logic       bb,
    input  logic       hc,
    input  logic       tm,
    output logic [2:0] out
);

    typedef enum logic [3:0] {
        IDLE         = 4'b0000,
        MONEDA       = 4'b0001,
        ESPERA_BOTON = 4'b0010,
        SIN_AGUA     = 4'b0100,
        SIN_CAFE     = 4'b0101,
        SALDO_INSUF  = 4'b0110,
        SERVIR_CAFE  = 4'b1001,
        SERVIR_TE    = 4'b1010
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_tm_lat;
    logic       w_tm_next;
    logic [2:0] r_out;

    // out[2]=coin/change return, out[1]=tea, out[0]=coffee
    function automatic logic [2:0] decode(input state_t s, input logic t);
        case (s)
            SIN_AGUA, SIN_CAFE, SALDO_INSUF: decode = 3'b100;
            SERVIR_CAFE:                     decode = 3'b001;
            SERVIR_TE:                       decode = {~t, 2'b10};
            default:                         decode = 3'b000;
        endcase
    endfunction

    always_comb begin
        w_next    = r_state;
        w_tm_next = r_tm_lat;
        case (r_state)
            IDLE: begin
                if (hm) begin
                    w_next    = MONEDA;
                    w_tm_next = tm;
                end
            end
            MONEDA:
                w_next = ha ? ESPERA_BOTON : SIN_AGUA;
            ESPERA_BOTON: begin
                // Priority: water, then tea, then coffee stock, then coin value.
                if (bp) begin
                    if (!ha)          w_next = SIN_AGUA;
                    else if (bb)      w_next = SERVIR_TE;
                    else if (!hc)     w_next = SIN_CAFE;
                    else if (r_tm_lat) w_next = SALDO_INSUF;
                    else              w_next = SERVIR_CAFE;
                end
            end
            SIN_AGUA:
                w_next = IDLE;
            SIN_CAFE, SALDO_INSUF, SERVIR_CAFE, SERVIR_TE: begin
                if (!bp) w_next = IDLE;
            end
            default:
                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_tm_lat <= 1'b0;
            r_out    <= 3'b000;
        end else begin
            r_state  <= w_next;
            r_tm_lat <= w_tm_next;
            r_out    <= decode(w_next, w_tm_next);
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_maquina_de_cafe.sv
// Bench for maquina_de_cafe: cycle-by-cycle vector table plus an async-reset sequence.
module tb_maquina_de_cafe;

    logic       clk;
    logic       rst;
    logic       hm, ha, bp, bb, hc, tm;
    logic [2:0] out;

    maquina_de_cafe dut (
        .clk (clk),
        .rst (rst),
        .hm  (hm),
        .ha  (ha),
        .bp  (bp),
        .bb  (bb),
        .hc  (hc),
        .tm  (tm),
        .out (out)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       hm, ha, bp, bb, hc, tm;
        logic [3:0] st;
        logic [2:0] o;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic vec_t mk(input logic [5:0] ins, input logic [3:0] st, input logic [2:0] o);
        vec_t v;
        {v.hm, v.ha, v.bp, v.bb, v.hc, v.tm} = ins;
        v.st = st;
        v.o  = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got state=%b out=%b, expected state=%b out=%b",
                      name, act[6:3], act[2:0], expv[6:3], expv[2:0]);
    endtask

    // driver: apply inputs, queue the expectation, compare after the edge
    task automatic step(input string name, input vec_t v);
        logic [6:0] e;
        {hm, ha, bp, bb, hc, tm} = {v.hm, v.ha, v.bp, v.bb, v.hc, v.tm};
        exp_q.push_back({v.st, v.o});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {dut.r_state, out}, e);
        end
    endtask

    initial begin
        //            {hm,ha,bp,bb,hc,tm}
        // tea, large coin, held then released
        vecs.push_back(mk(6'b110000, 4'b0001, 3'b000));
        vecs.push_back(mk(6'b010000, 4'b0010, 3'b000));
        vecs.push_back(mk(6'b011100, 4'b1010, 3'b110));
        vecs.push_back(mk(6'b011100, 4'b1010, 3'b110));
        vecs.push_back(mk(6'b010000, 4'b0000, 3'b000));
        // coffee, large coin
        vecs.push_back(mk(6'b110010, 4'b0001, 3'b000));
        vecs.push_back(mk(6'b010010, 4'b0010, 3'b000));
        vecs.push_back(mk(6'b011010, 4'b1001, 3'b001));
        vecs.push_back(mk(6'b010010, 4'b0000, 3'b000));
        // coffee, small coin: insufficient, held then released
        vecs.push_back(mk(6'b110011, 4'b0001, 3'b000));
        vecs.push_back(mk(6'b010010, 4'b0010, 3'b000));
        vecs.push_back(mk(6'b011010, 4'b0110, 3'b100));
        vecs.push_back(mk(6'b011010, 4'b0110, 3'b100));
        vecs.push_back(mk(6'b010010, 4'b0000, 3'b000));
        // tea, small coin: exact
        vecs.push_back(mk(6'b110001, 4'b0001, 3'b000));
        vecs.push_back(mk(6'b010000, 4'b0010, 3'b000));
        vecs.push_back(mk(6'b011100, 4'b1010, 3'b010));
        vecs.push_back(mk(6'b010000, 4'b0000, 3'b000));
        // no water at coin: one cycle of SIN_AGUA
        vecs.push_back(mk(6'b100000, 4'b0001, 3'b000));
        vecs.push_back(mk(6'b000000, 4'b0100, 3'b100));
        vecs.push_back(mk(6'b000000, 4'b0000, 3'b000));
        // water lost together with bp in ESPERA_BOTON
        vecs.push_back(mk(6'b110000, 4'b0001, 3'b000));
        vecs.push_back(mk(6'b010000, 4'b0010, 3'b000));
        vecs.push_back(mk(6'b001100, 4'b0100, 3'b100));
        vecs.push_back(mk(6'b001100, 4'b0000, 3'b000));
        // no coffee stock
        vecs.push_back(mk(6'b110000, 4'b0001, 3'b000));
        vecs.push_back(mk(6'b010000, 4'b0010, 3'b000));
        vecs.push_back(mk(6'b011000, 4'b0101, 3'b100));
        vecs.push_back(mk(6'b011000, 4'b0101, 3'b100));
        vecs.push_back(mk(6'b010000, 4'b0000, 3'b000));
        // second coin in ESPERA_BOTON ignored; tm not relatched
        vecs.push_back(mk(6'b110010, 4'b0001, 3'b000));
        vecs.push_back(mk(6'b010010, 4'b0010, 3'b000));
        vecs.push_back(mk(6'b110011, 4'b0010, 3'b000));
        vecs.push_back(mk(6'b011010, 4'b1001, 3'b001));
        vecs.push_back(mk(6'b010010, 4'b0000, 3'b000));
        // idle stays idle without coin
        vecs.push_back(mk(6'b011111, 4'b0000, 3'b000));
    end

    initial begin
        {hm, ha, bp, bb, hc, tm} = 6'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {dut.r_state, out}, 7'b0000_000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset_release", {dut.r_state, out}, 7'b0000_000);

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // async reset in the middle of a tea serve
        step("rst_seq_coin",  mk(6'b110000, 4'b0001, 3'b000));
        step("rst_seq_water", mk(6'b010000, 4'b0010, 3'b000));
        step("rst_seq_tea",   mk(6'b011100, 4'b1010, 3'b110));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_immediate", {dut.r_state, out}, 7'b0000_000);
        n_checks++;
        if (dut.r_tm_lat === 1'b0) n_pass++;
        else $display("FAIL async_rst_tm_lat: got %b expected 0", dut.r_tm_lat);
        #2;
        rst = 1'b1;
        step("post_rst_bp_held", mk(6'b011100, 4'b0000, 3'b000));
        step("post_rst_coin",    mk(6'b110001, 4'b0001, 3'b000));
        step("post_rst_water",   mk(6'b010001, 4'b0010, 3'b000));
        step("post_rst_tea_sm",  mk(6'b011101, 4'b1010, 3'b010));
        step("post_rst_release", mk(6'b010000, 4'b0000, 3'b000));

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
